// File: rtl/seq_left_shifter.sv
// seq_left_shifter
//
// Iterative left shifter. It moves one bit position per clock and uses a
// start/busy/done handshake. On an accepted start it latches the operand,
// the shift amount (clamped to WIDTH) and the fill bit. It then shifts
// serially and presents a held result together with carry/overflow flags.
//
// Ports:
//   CLK           rising-edge clock
//   RST           synchronous reset, active-high, overrides everything
//   start         request; accepted only when idle and not presenting done
//   data_in       operand, captured on accepted start
//   shamt         shift amount, captured on accepted start (>= WIDTH clamps)
//   fill_bit      value shifted into the LSB, captured on accepted start
//   data_out      result register, held until the next operation completes
//   carry_out     last bit shifted out of the MSB (0 for a zero shift)
//   lost_nonzero  1 if any 1 bit left the MSB during the operation
//   busy          high while an operation is in flight, including the done cycle
//   done          single-cycle pulse; data_out/carry_out/lost_nonzero are valid
//
// Handshake: a request is taken on a rising edge where start = 1 and busy = 0.
// Once it is taken, busy rises and start, data_in, shamt and fill_bit are
// ignored until busy falls again. done pulses for exactly one cycle as the
// last cycle of busy. Because busy is still high during that cycle, a start
// asserted then is ignored. The earliest new request is the cycle after done.
//
// busy, done and the result registers are registered images of the FSM. They
// lag the state register by one cycle. With the load edge numbered 0 and n the
// clamped count, done is therefore high in the cycle after edge n + 1.

module seq_left_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               fill_bit,
    output logic [WIDTH-1:0]   data_out,
    output logic               carry_out,
    output logic               lost_nonzero,
    output logic               busy,
    output logic               done
);

    // The counter must be able to hold WIDTH itself (the clamped case).
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] work_q;
    logic             fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             lost_q;

    logic             load;
    logic [CNT_W-1:0] cnt_load;

    // Clamp the requested amount to WIDTH.
    always_comb begin
        cnt_load = CNT_ZERO;
        if (32'(shamt) >= WIDTH) begin
            cnt_load = CNT_W'(WIDTH);
        end else begin
            cnt_load = CNT_W'(shamt);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. While done is showing, the state is already IDLE.
    // The !done term keeps a start in that cycle from being taken.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !done) begin
                    load    = 1'b1;
                    state_d = (cnt_load == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            work_q       <= '0;
            fill_q       <= 1'b0;
            cnt_q        <= CNT_ZERO;
            carry_q      <= 1'b0;
            lost_q       <= 1'b0;
            data_out     <= '0;
            carry_out    <= 1'b0;
            lost_nonzero <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            busy <= (state_q != ST_IDLE);
            done <= (state_q == ST_DONE);

            if (load) begin
                work_q  <= data_in;
                fill_q  <= fill_bit;
                cnt_q   <= cnt_load;
                carry_q <= 1'b0;
                lost_q  <= 1'b0;
            end else if (state_q == ST_SHIFT) begin
                work_q  <= {work_q[WIDTH-2:0], fill_q};
                carry_q <= work_q[WIDTH-1];
                lost_q  <= lost_q | work_q[WIDTH-1];
                cnt_q   <= cnt_q - CNT_ONE;
            end

            // The work register is frozen in DONE, so the result is captured there.
            if (state_q == ST_DONE) begin
                data_out     <= work_q;
                carry_out    <= carry_q;
                lost_nonzero <= lost_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_left_shifter.sv
module tb_seq_left_shifter;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 5;

    logic               CLK;
    logic               RST;
    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               fill_bit;
    logic [WIDTH-1:0]   data_out;
    logic               carry_out;
    logic               lost_nonzero;
    logic               busy;
    logic               done;

    int n_assert = 0;
    int n_fail   = 0;

    seq_left_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .data_in      (data_in),
        .shamt        (shamt),
        .fill_bit     (fill_bit),
        .data_out     (data_out),
        .carry_out    (carry_out),
        .lost_nonzero (lost_nonzero),
        .busy         (busy),
        .done         (done)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a left shift by the clamped amount, done with wide
    // arithmetic. The bits pushed above WIDTH are the lost bits. The lowest of
    // them is the last bit shifted out.
    task automatic model(input logic [WIDTH-1:0] d, input int sh, input logic f,
                         output logic [WIDTH-1:0] r, output logic c, output logic l,
                         output int n);
        longint v;
        longint hi;
        longint fm;
        n  = (sh > WIDTH) ? WIDTH : sh;
        v  = longint'(d) << n;
        fm = f ? ((longint'(1) << n) - 1) : 0;
        r  = WIDTH'(v | fm);
        hi = v >> WIDTH;
        c  = hi[0];
        l  = (hi != 0);
    endtask

    // Run one operation and check its latency, busy/done shape and result.
    // With hold = 1, start stays high through the busy window and the done
    // cycle, carrying a conflicting request that must be ignored.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] d,
                          input logic [SHAMT_W-1:0] sh, input logic f, input bit hold);
        logic [WIDTH-1:0] exp_r;
        logic             exp_c;
        logic             exp_l;
        int               n;
        int               done_edge;
        int               done_cnt;
        int               busy_cnt;
        model(d, int'(sh), f, exp_r, exp_c, exp_l, n);
        @(negedge CLK);
        start    = 1'b1;
        data_in  = d;
        shamt    = sh;
        fill_bit = f;
        @(posedge CLK);                 // load edge (edge 0)
        #1;
        if (hold) begin
            data_in  = 16'hFFFF;
            shamt    = SHAMT_W'(1);
            fill_bit = 1'b1;
        end else begin
            start    = 1'b0;
            data_in  = WIDTH'($urandom);
            shamt    = SHAMT_W'($urandom);
            fill_bit = 1'($urandom);
        end
        done_edge = -1;
        done_cnt  = 0;
        busy_cnt  = 0;
        for (int k = 1; k <= n + 5; k++) begin
            @(posedge CLK);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end else if (done_cnt > 0) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " done_edge"}, 32'(done_edge), 32'(n + 1));
        check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, " busy_cnt"}, 32'(busy_cnt), 32'(n + 1));
        check({tag, " data_out"}, 32'(data_out), 32'(exp_r));
        check({tag, " carry_out"}, 32'(carry_out), 32'(exp_c));
        check({tag, " lost_nonzero"}, 32'(lost_nonzero), 32'(exp_l));
    endtask

    initial begin
        int seen_done;
        RST      = 1'b1;
        start    = 1'b0;
        data_in  = '0;
        shamt    = '0;
        fill_bit = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst data_out", 32'(data_out), 32'd0);
        check("rst carry_out", 32'(carry_out), 32'd0);
        check("rst lost_nonzero", 32'(lost_nonzero), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        RST = 1'b0;

        // Directed cases
        run_op("t1", 16'h8001, 5'd1, 1'b0, 1'b0);
        check("t1 lit data", 32'(data_out), 32'h0002);
        run_op("t2", 16'h00FF, 5'd4, 1'b0, 1'b0);
        check("t2 lit data", 32'(data_out), 32'h0FF0);
        run_op("t3", 16'h1234, 5'd0, 1'b0, 1'b0);
        check("t3 lit data", 32'(data_out), 32'h1234);
        run_op("t4", 16'h0001, 5'd20, 1'b1, 1'b0);
        check("t4 lit data", 32'(data_out), 32'hFFFF);
        run_op("t5", 16'h00F0, 5'd8, 1'b0, 1'b1);
        check("t5 lit data", 32'(data_out), 32'hF000);
        run_op("t6", 16'hA5C3, 5'd16, 1'b0, 1'b0);
        run_op("t7", 16'h0000, 5'd31, 1'b1, 1'b0);

        // Reset in the middle of an operation
        @(negedge CLK);
        start    = 1'b1;
        data_in  = 16'h00F0;
        shamt    = 5'd8;
        fill_bit = 1'b0;
        @(posedge CLK);                 // edge 0
        #1;
        start = 1'b0;
        @(posedge CLK);                 // edge 1
        @(posedge CLK);                 // edge 2: third SHIFT cycle follows
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("midrst data_out", 32'(data_out), 32'd0);
        check("midrst carry_out", 32'(carry_out), 32'd0);
        check("midrst lost_nonzero", 32'(lost_nonzero), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            if (done || busy) seen_done++;
        end
        check("midrst quiet", 32'(seen_done), 32'd0);
        run_op("t8", 16'h0003, 5'd2, 1'b0, 1'b0);
        check("t8 lit data", 32'(data_out), 32'h000C);

        // Random operations, some with start held high throughout
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rnd%0d", i), WIDTH'($urandom),
                   SHAMT_W'($urandom_range(0, 31)), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
